// File: rtl/move_sort_topk.sv
// In-place RAM move sorter with a masked-flag/signed-eval priority key.
// Backward bubble passes carry the best entry to index 0. A pass ends the
// sort early if it made no swap, if the unsorted tail shrank to one entry,
// or, in top-K mode, once K leading entries are final.
// Ports: clk/reset (async active-low); sort_start (rising edge, IDLE only),
// sort_clear (DONE -> IDLE), descending, flag_mask, top_k; external writer
// (ram_wr_addr_init, ram_wr, ram_wr_data, ram_wr_addr, entry_count, overflow)
// and reader (ram_rd_addr, ram_rd_data); status sort_busy, sort_complete,
// pass_count.
module move_sort_topk #(
  parameter int unsigned RAM_WIDTH          = 16,
  parameter int unsigned EVAL_WIDTH         = 8,
  parameter int unsigned FLAG_WIDTH         = 4,
  parameter int unsigned RD_LATENCY         = 2,
  parameter int unsigned MAX_POSITIONS_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sort_start,
  input  logic                          sort_clear,
  input  logic                          descending,
  input  logic [FLAG_WIDTH-1:0]         flag_mask,
  input  logic [MAX_POSITIONS_LOG2-1:0] top_k,
  input  logic                          ram_wr_addr_init,
  input  logic                          ram_wr,
  input  logic [RAM_WIDTH-1:0]          ram_wr_data,
  input  logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr,
  output logic [RAM_WIDTH-1:0]          ram_rd_data,
  output logic [MAX_POSITIONS_LOG2-1:0] ram_wr_addr,
  output logic [MAX_POSITIONS_LOG2:0]   entry_count,
  output logic                          overflow,
  output logic                          sort_busy,
  output logic                          sort_complete,
  output logic [MAX_POSITIONS_LOG2-1:0] pass_count
);

  localparam int unsigned L       = MAX_POSITIONS_LOG2;
  localparam int unsigned CW      = L + 1;
  localparam int unsigned MAX_POS = 1 << L;
  localparam int unsigned KW      = EVAL_WIDTH + FLAG_WIDTH;
  localparam int unsigned WW      = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PASS_INIT, ST_READ, ST_COMPARE, ST_SWAP, ST_STEP, ST_PASS_END, ST_DONE
  } state_t;

  state_t                 state_q, state_nxt;
  logic                   start_q;
  logic [CW-1:0]          n_q, n_nxt, cnt_q, cnt_nxt;
  logic [FLAG_WIDTH-1:0]  mask_q, mask_nxt;
  logic [L-1:0]           k_q, k_nxt, lo_q, lo_nxt, i_q, i_nxt;
  logic [L-1:0]           passes_q, passes_nxt, ptr_q, ptr_nxt, pass_cnt_q, pass_cnt_nxt;
  logic                   swapped_q, swapped_nxt;
  logic [WW-1:0]          wait_q, wait_nxt;
  logic                   ovf_q, ovf_nxt, busy_q, busy_nxt, done_q, done_nxt;

  logic                   ext_we, sorting, start_rise, swap_c;
  logic [L-1:0]           ext_addr, im1, n_last, lo_inc, passes_inc;
  logic [L-1:0]           addr_a, addr_b;
  logic                   we_a, we_b;
  logic [RAM_WIDTH-1:0]   wd_a, wd_b, rd_a, rd_b;
  logic [RAM_WIDTH-1:0]   mem [MAX_POS];
  logic [RAM_WIDTH-1:0]   pipe_a [RD_LATENCY];
  logic [RAM_WIDTH-1:0]   pipe_b [RD_LATENCY];

  logic [FLAG_WIDTH-1:0]        flag_a, flag_b;
  logic signed [EVAL_WIDTH-1:0] eval_a, eval_b;

  assign start_rise = sort_start & ~start_q;
  assign sorting    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign im1        = i_q - L'(1);
  assign n_last     = L'(n_q - CW'(1));
  assign lo_inc     = lo_q + L'(1);
  assign passes_inc = passes_q + L'(1);

  // Port a: external writer when idle, entry i-1 while sorting; port b: reader / entry i.
  assign addr_a = sorting ? im1 : ext_addr;
  assign addr_b = sorting ? i_q : ram_rd_addr;
  assign rd_a   = pipe_a[RD_LATENCY-1];
  assign rd_b   = pipe_b[RD_LATENCY-1];
  assign we_a   = ext_we || (state_q == ST_SWAP);
  assign we_b   = (state_q == ST_SWAP);
  assign wd_a   = (state_q == ST_SWAP) ? rd_b : ram_wr_data;
  assign wd_b   = rd_a;

  // Key compare: masked flags as unsigned (highest differing bit wins), then signed eval.
  assign flag_a = rd_a[KW-1:EVAL_WIDTH] & mask_q;
  assign flag_b = rd_b[KW-1:EVAL_WIDTH] & mask_q;
  assign eval_a = $signed(rd_a[EVAL_WIDTH-1:0]);
  assign eval_b = $signed(rd_b[EVAL_WIDTH-1:0]);
  assign swap_c = (flag_a != flag_b) ? (flag_b > flag_a)
                : (descending ? (eval_b > eval_a) : (eval_b < eval_a));

  // Dual-port RAM array; contents are not reset.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    if (we_b) mem[addr_b] <= wd_b;
  end

  // Read pipelines giving RD_LATENCY cycles from address to data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < int'(RD_LATENCY); j++) begin
        pipe_a[j] <= '0;
        pipe_b[j] <= '0;
      end
    end else begin
      pipe_a[0] <= mem[addr_a];
      pipe_b[0] <= mem[addr_b];
      for (int j = 1; j < int'(RD_LATENCY); j++) begin
        pipe_a[j] <= pipe_a[j-1];
        pipe_b[j] <= pipe_b[j-1];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      k_q        <= '0;
      lo_q       <= '0;
      i_q        <= '0;
      passes_q   <= '0;
      ptr_q      <= '0;
      pass_cnt_q <= '0;
      swapped_q  <= 1'b0;
      wait_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      start_q    <= sort_start;
      n_q        <= n_nxt;
      cnt_q      <= cnt_nxt;
      mask_q     <= mask_nxt;
      k_q        <= k_nxt;
      lo_q       <= lo_nxt;
      i_q        <= i_nxt;
      passes_q   <= passes_nxt;
      ptr_q      <= ptr_nxt;
      pass_cnt_q <= pass_cnt_nxt;
      swapped_q  <= swapped_nxt;
      wait_q     <= wait_nxt;
      ovf_q      <= ovf_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
    end
  end

  // Next-state, datapath and external-write logic.
  always_comb begin
    state_nxt    = state_q;
    n_nxt        = n_q;
    cnt_nxt      = cnt_q;
    mask_nxt     = mask_q;
    k_nxt        = k_q;
    lo_nxt       = lo_q;
    i_nxt        = i_q;
    passes_nxt   = passes_q;
    ptr_nxt      = ptr_q;
    pass_cnt_nxt = pass_cnt_q;
    swapped_nxt  = swapped_q;
    wait_nxt     = wait_q;
    ovf_nxt      = ovf_q;
    ext_we       = 1'b0;
    ext_addr     = ptr_q;

    if (!sorting) begin
      if (ram_wr_addr_init) begin
        ovf_nxt = 1'b0;
        if (ram_wr) begin
          ext_we   = 1'b1;
          ext_addr = '0;
          ptr_nxt  = L'(1);
          cnt_nxt  = CW'(1);
        end else begin
          ptr_nxt = '0;
          cnt_nxt = '0;
        end
      end else if (ram_wr) begin
        if (cnt_q == CW'(MAX_POS)) begin
          ovf_nxt = 1'b1;
        end else begin
          ext_we  = 1'b1;
          ptr_nxt = ptr_q + L'(1);
          cnt_nxt = cnt_q + CW'(1);
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          n_nxt      = cnt_q;
          mask_nxt   = flag_mask;
          k_nxt      = top_k;
          lo_nxt     = '0;
          passes_nxt = '0;
          if (cnt_q <= CW'(1)) begin
            pass_cnt_nxt = '0;
            state_nxt    = ST_DONE;
          end else begin
            state_nxt = ST_PASS_INIT;
          end
        end
      end
      ST_PASS_INIT: begin
        i_nxt       = n_last;
        swapped_nxt = 1'b0;
        wait_nxt    = '0;
        state_nxt   = ST_READ;
      end
      ST_READ: begin
        if (wait_q == WW'(RD_LATENCY - 1)) state_nxt = ST_COMPARE;
        else wait_nxt = wait_q + WW'(1);
      end
      ST_COMPARE: state_nxt = swap_c ? ST_SWAP : ST_STEP;
      ST_SWAP: begin
        swapped_nxt = 1'b1;
        state_nxt   = ST_STEP;
      end
      ST_STEP: begin
        if (im1 == lo_q) begin
          state_nxt = ST_PASS_END;
        end else begin
          i_nxt     = im1;
          wait_nxt  = '0;
          state_nxt = ST_READ;
        end
      end
      ST_PASS_END: begin
        passes_nxt = passes_inc;
        lo_nxt     = lo_inc;
        if (!swapped_q || (lo_inc == n_last) || ((k_q != '0) && (passes_inc == k_q))) begin
          pass_cnt_nxt = passes_inc;
          state_nxt    = ST_DONE;
        end else begin
          state_nxt = ST_PASS_INIT;
        end
      end
      ST_DONE: if (sort_clear) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    done_nxt = (state_nxt == ST_DONE);
  end

  assign ram_rd_data   = rd_b;
  assign ram_wr_addr   = ptr_q;
  assign entry_count   = cnt_q;
  assign overflow      = ovf_q;
  assign sort_busy     = busy_q;
  assign sort_complete = done_q;
  assign pass_count    = pass_cnt_q;

endmodule
